// File: rtl/usb_fifo_pkg.sv
// Shared types and helpers for the USB packet FIFO pointer logic.
// Pointers carry one extra wrap bit beyond the address so full and empty stay distinguishable.
package usb_fifo_pkg;

  localparam int unsigned DEFAULT_DEPTH = 64;

  function automatic int unsigned ptr_wid(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  typedef logic [$clog2(DEFAULT_DEPTH):0] fifo_ptr_t;

endpackage

// File: rtl/mem.sv
// Generic simple dual-port memory: synchronous write, registered read.
// A read of an address written on the same edge returns the previous contents.
module mem #(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned DATA_WID = 8,
  localparam int unsigned ADDR_WID = $clog2(DEPTH)
) (
  input  logic                clk_i,
  input  logic                wEn_i,
  input  logic [ADDR_WID-1:0] wAddr_i,
  input  logic [DATA_WID-1:0] wData_i,
  input  logic [ADDR_WID-1:0] rAddr_i,
  output logic [DATA_WID-1:0] rData_o
);

  logic [DATA_WID-1:0] storage_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wEn_i) begin
      storage_q[wAddr_i] <= wData_i;
    end
    rData_o <= storage_q[rAddr_i];
  end

endmodule

// File: rtl/usb_packet_fifo_ctrl.sv
// Pointer and flow-control stage driving a dual-port mem as a packet FIFO with
// tentative staging (commit/revert) on the write side and FWFT valid/ready reads.
module usb_packet_fifo_ctrl
  import usb_fifo_pkg::*;
#(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned DATA_WID = 8,
  localparam int unsigned ADDR_WID = $clog2(DEPTH)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                wValid_i,
  input  logic [DATA_WID-1:0] wData_i,
  output logic                wReady_o,
  input  logic                wCommit_i,
  input  logic                wRevert_i,
  output logic                rValid_o,
  output logic [DATA_WID-1:0] rData_o,
  input  logic                rReady_i,
  output logic [ADDR_WID:0]   level_o,
  output logic                memWEn_o,
  output logic [ADDR_WID-1:0] memWAddr_o,
  output logic [DATA_WID-1:0] memWData_o,
  output logic [ADDR_WID-1:0] memRAddr_o,
  input  logic [DATA_WID-1:0] memRData_i
);

  localparam int unsigned PTR_WID = ptr_wid(DEPTH);
  typedef logic [PTR_WID-1:0] ptr_t;

  ptr_t w_ptr_q, w_ptr_d;
  ptr_t c_ptr_q, c_ptr_d;
  ptr_t r_ptr_q, r_ptr_d;
  ptr_t r_ptr_nxt;
  logic r_valid_q, r_valid_d;
  logic full;
  logic accept;
  logic pop;

  // rValid compares against the registered commit pointer, so a word is only
  // presented once its mem write has landed at least one edge earlier.
  always_comb begin
    full      = (w_ptr_q - r_ptr_q) == ptr_t'(DEPTH);
    accept    = wValid_i && !full && !wRevert_i;
    pop       = r_valid_q && rReady_i;
    r_ptr_nxt = r_ptr_q + ptr_t'(pop);
    w_ptr_d   = w_ptr_q + ptr_t'(accept);
    c_ptr_d   = c_ptr_q;
    if (wRevert_i) begin
      w_ptr_d = c_ptr_q;
    end else if (wCommit_i) begin
      c_ptr_d = w_ptr_d;
    end
    r_ptr_d   = r_ptr_nxt;
    r_valid_d = r_ptr_nxt != c_ptr_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_ptr_q   <= '0;
      c_ptr_q   <= '0;
      r_ptr_q   <= '0;
      r_valid_q <= 1'b0;
    end else begin
      w_ptr_q   <= w_ptr_d;
      c_ptr_q   <= c_ptr_d;
      r_ptr_q   <= r_ptr_d;
      r_valid_q <= r_valid_d;
    end
  end

  assign wReady_o   = !full;
  assign memWEn_o   = accept;
  assign memWAddr_o = w_ptr_q[ADDR_WID-1:0];
  assign memWData_o = wData_i;
  assign memRAddr_o = r_ptr_nxt[ADDR_WID-1:0];
  assign rValid_o   = r_valid_q;
  assign rData_o    = memRData_i;
  assign level_o    = c_ptr_q - r_ptr_q;

endmodule

// File: tb/tb_usb_packet_fifo_ctrl.sv
// Self-checking bench for usb_packet_fifo_ctrl with an attached mem, compared
// cycle by cycle against a queue-based model of staged and committed packet data.
module tb_usb_packet_fifo_ctrl;

  localparam int DEPTH    = 4;
  localparam int DATA_WID = 8;
  localparam int ADDR_WID = 2;

  logic                clk;
  logic                rstN;
  logic                wValid;
  logic [DATA_WID-1:0] wData;
  logic                wReady;
  logic                wCommit;
  logic                wRevert;
  logic                rValid;
  logic [DATA_WID-1:0] rData;
  logic                rReady;
  logic [ADDR_WID:0]   level;
  logic                memWEn;
  logic [ADDR_WID-1:0] memWAddr;
  logic [DATA_WID-1:0] memWData;
  logic [ADDR_WID-1:0] memRAddr;
  logic [DATA_WID-1:0] memRData;

  usb_packet_fifo_ctrl #(.DEPTH(DEPTH), .DATA_WID(DATA_WID)) dut (
    .clk_i(clk), .rst_ni(rstN),
    .wValid_i(wValid), .wData_i(wData), .wReady_o(wReady),
    .wCommit_i(wCommit), .wRevert_i(wRevert),
    .rValid_o(rValid), .rData_o(rData), .rReady_i(rReady),
    .level_o(level),
    .memWEn_o(memWEn), .memWAddr_o(memWAddr), .memWData_o(memWData),
    .memRAddr_o(memRAddr), .memRData_i(memRData)
  );

  mem #(.DEPTH(DEPTH), .DATA_WID(DATA_WID)) uMem (
    .clk_i(clk), .wEn_i(memWEn), .wAddr_i(memWAddr), .wData_i(memWData),
    .rAddr_i(memRAddr), .rData_o(memRData)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int errorCount = 0;

  // Reference model: words waiting for commit, words committed and unread,
  // and the running count of committed words that fixes the write address.
  logic [7:0] stagedQ[$];
  logic [7:0] committedQ[$];
  int         totalCommitted = 0;
  bit         expValid = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drive one cycle, check outputs at the falling edge, then advance the model
  // across the rising edge. Committed data becomes visible one cycle after the
  // commit edge has been seen by the read side.
  task automatic applyStimulus(input bit wv, input logic [7:0] wd, input bit commit,
                               input bit revert, input bit rready);
    bit expReady;
    bit expWEn;
    bit popNow;
    int lvlBefore;
    wValid  = wv;
    wData   = wd;
    wCommit = commit;
    wRevert = revert;
    rReady  = rready;
    @(negedge clk);
    expReady = (committedQ.size() + stagedQ.size()) < DEPTH;
    expWEn   = wv && expReady && !revert;
    checkOutput("wReady", 32'(wReady), 32'(expReady));
    checkOutput("memWEn", 32'(memWEn), 32'(expWEn));
    if (expWEn) begin
      checkOutput("memWAddr", 32'(memWAddr), 32'((totalCommitted + stagedQ.size()) % DEPTH));
      checkOutput("memWData", 32'(memWData), 32'(wd));
    end
    checkOutput("level", 32'(level), 32'(committedQ.size()));
    checkOutput("rValid", 32'(rValid), 32'(expValid));
    if (expValid && committedQ.size() > 0) begin
      checkOutput("rData", 32'(rData), 32'(committedQ[0]));
    end
    @(posedge clk);
    lvlBefore = committedQ.size();
    popNow    = expValid && rready;
    if (popNow) void'(committedQ.pop_front());
    if (expWEn) stagedQ.push_back(wd);
    if (revert) begin
      stagedQ.delete();
    end else if (commit) begin
      totalCommitted += stagedQ.size();
      while (stagedQ.size() > 0) committedQ.push_back(stagedQ.pop_front());
    end
    expValid = (lvlBefore - int'(popNow)) > 0;
    #1;
  endtask

  task automatic drain(input int cycles);
    for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic doReset();
    #2;
    rstN    = 1'b0;
    wValid  = 1'b0;
    wCommit = 1'b0;
    wRevert = 1'b0;
    rReady  = 1'b0;
    #1;
    checkOutput("rstRValid", 32'(rValid), 32'd0);
    checkOutput("rstLevel", 32'(level), 32'd0);
    checkOutput("rstWReady", 32'(wReady), 32'd1);
    checkOutput("rstMemWEn", 32'(memWEn), 32'd0);
    stagedQ.delete();
    committedQ.delete();
    totalCommitted = 0;
    expValid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rstN = 1'b1;
  endtask

  initial begin
    int sent;
    bit wv;
    bit cm;
    clk     = 1'b0;
    rstN    = 1'b1;
    wValid  = 1'b0;
    wData   = '0;
    wCommit = 1'b0;
    wRevert = 1'b0;
    rReady  = 1'b0;

    doReset();

    // Three-word packet committed on the last word, then read out back to back.
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
    drain(6);

    // Reverted packet is never visible; the following packet is.
    applyStimulus(1'b1, 8'hA0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'hA1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    drain(2);
    applyStimulus(1'b1, 8'hB0, 1'b1, 1'b0, 1'b1);
    drain(4);

    // Fill to DEPTH, try a fifth write, commit, pop once, confirm space returns.
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hC4, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    drain(6);

    // Commit and revert together: revert wins and the same-cycle write is dropped.
    applyStimulus(1'b1, 8'h44, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h55, 1'b1, 1'b1, 1'b0);
    drain(5);

    // Twenty-word stream with a commit every third word and random back-pressure.
    sent = 0;
    for (int cyc = 0; cyc < 300 && (sent < 20 || committedQ.size() > 0 || expValid); cyc++) begin
      wv = sent < 20;
      cm = wv && ((sent % 3) == 2 || sent == 19);
      if (wv && (committedQ.size() + stagedQ.size()) < DEPTH) begin
        applyStimulus(wv, 8'(8'h60 + sent), cm, 1'b0, 1'($urandom_range(0, 1)));
        sent++;
      end else begin
        applyStimulus(wv, 8'(8'h60 + sent), cm, 1'b0, 1'($urandom_range(0, 1)));
      end
    end
    checkOutput("streamSent", 32'(sent), 32'd20);
    drain(4);

    // Fully random traffic, including reverts and overlapping commit/revert.
    for (int cyc = 0; cyc < 400; cyc++) begin
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                    $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                    1'($urandom_range(0, 1)));
    end
    drain(8);

    // Reset mid-packet with committed data pending.
    applyStimulus(1'b1, 8'h71, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h72, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h73, 1'b0, 1'b0, 1'b0);
    doReset();
    drain(6);
    applyStimulus(1'b1, 8'h81, 1'b1, 1'b0, 1'b1);
    drain(4);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
